txfifo_ser: RTL and testbench
=============================

Name: txfifo_ser

Overview:
- Transmit-side counterpart of the receive FIFO path: host writes bytes into a small FIFO; a serializer drains it onto a UART-style line (start, 8 data LSB-first, stop).
- Sits between the host bus interface and the physical TX pin.
- Uses the same valid-bit FIFO organisation and falling-edge timing as the receive side.

Parameters:
- FIFOSZ, 3, number of FIFO entries; must be >=2.
- FIFOPTRSZ, 2, pointer width; equals roundup(log2(FIFOSZ)).
- CLKDIV, 16, clk cycles per serial bit; must be >=2.
- CNTSZ, 4, bit-timer width; must be able to hold CLKDIV-1.

Ports:
- clk  input  1  system clock; all state updates on the falling edge.
- reset_b  input  1  asynchronous, active-low reset.
- host_din  input  8  byte from host.
- host_we  input  1  host write strobe.
- host_dir  output  1  ready for input from host (FIFO not completely full).
- empty  output  1  no valid FIFO entries and serializer idle.
- cts_b  input  1  clear-to-send, active-low; sampled only at frame start.
- tx_busy  output  1  serializer mid-frame.
- txd  output  1  serial line, registered, idle high.

Behaviour:
- Reset (async, reset_b low):
  - all valid bits, wptr and rptr = 0; state = IDLE; bit timer = 0; bit index = 0.
  - txd = 1, tx_busy = 0, host_dir = 1, empty = 1.
  - A frame in progress is abandoned and the line returns high immediately.
- FIFO:
  - host_dir = !(&valid). This is combinational from the current valid bits.
  - Write: on a falling edge with host_we & !valid[wptr], store host_din, set valid[wptr], and advance wptr, wrapping FIFOSZ-1 -> 0. A write to a full FIFO is silently dropped.
  - Pop: the serializer pops only in IDLE. Pop clears valid[rptr] and advances rptr with the same wrap.
  - A write and a pop on the same edge both take effect. Fullness is judged on pre-edge state, so a write to a FIFO that is full before the edge is dropped even if a pop happens on that edge.
- Serializer states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
  - IDLE -> START: when valid[rptr] & !cts_b. On that edge: pop, load the shift register, txd <= 0, timer <= 0.
  - START: after CLKDIV cycles -> DATA; txd <= shreg[0]; bit index <= 0.
  - DATA: each bit is held CLKDIV cycles, then shift right and increment the index. After bit index 7 completes -> STOP; txd <= 1.
  - STOP: held CLKDIV cycles, then -> IDLE.
  - Back-to-back frames: if a STOP ending and an IDLE->START would fall on the same edge, the START is taken on the next edge. This gives a minimum inter-frame gap of one clk beyond a full stop bit.
- Latency:
  - Write at falling edge N to an empty, idle block (cts_b = 0): txd falls at edge N+1.
  - The frame occupies exactly (10 x CLKDIV) cycles from that edge, or 11 x CLKDIV with parity.
- tx_busy = (state != IDLE).
- Flow control: cts_b deasserting mid-frame does not truncate the frame. The next frame waits in IDLE until cts_b = 0.
- Bit timer: CNTSZ-bit counter, clears on every state/bit transition; no overflow is possible by parameter rule.

Optional Feature:
- Macro: TXFIFO_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKDIV cycles.
  - txd = even parity (XOR of the 8 data bits), computed on load and held in a register.
- Undefined: no PARITY state, no parity register; frame length is 10 bits.

Decomposition:
- Shared package/include:
  - FIFOSZ and FIFOPTRSZ defaults, shared with the receive FIFO.
  - State encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, in 3 bits.
  - Pointer-wrap rule.
- Sub-module: txfifo_buf, the storage, valid bits and pointers, exposing dout, dor, pop and dir. The serializer stays in the top module.

Test Plan:
- Reset, then CLKDIV=4, cts_b=0, write 0x55 -> txd 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles. tx_busy is high for 40 cycles, then empty=1.
- FIFOSZ=3, cts_b=1, write 0x01,0x02,0x03,0x04 on consecutive edges -> host_dir=0 after the third write. 0x04 is dropped, txd stays 1, and empty=0.
- Release cts_b=0 from the full state -> frames 0x01, 0x02, 0x03 appear in order, each followed by one extra idle-high clk. After the first pop, host_dir=1.
- Full FIFO with a pop and host_we in the same edge -> the write is dropped. A write on the next edge is accepted, and that byte is the fourth frame out.
- Assert reset_b low mid-DATA of 0xA5 -> txd=1 and tx_busy=0 immediately. After release, empty=1 and no further output.
- With TXFIFO_PARITY_EN, write 0x07 -> a parity bit of 1 follows data bit 7, and the frame is 44 cycles at CLKDIV=4.

Source files
------------

// File: rtl/txfifo_pkg.sv
// Shared definitions for the transmit FIFO and serializer.
// FIFO depth defaults match the receive side; the pointer-wrap helper is shared.
package txfifo_pkg;

    localparam int FIFOSZ_DEF    = 3;
    localparam int FIFOPTRSZ_DEF = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Next ring position: FIFOSZ-1 wraps back to 0.
    function automatic int unsigned ptr_next(int unsigned ptr, int unsigned sz);
        return (ptr + 1 >= sz) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/txfifo_buf.sv
// Transmit FIFO storage: per-entry valid bits with write and read pointers.
// All state changes on the falling edge of clk.
module txfifo_buf
    import txfifo_pkg::*;
#(
    parameter int FIFOSZ    = FIFOSZ_DEF,
    parameter int FIFOPTRSZ = FIFOPTRSZ_DEF
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic [7:0] din,
    input  logic       we,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       dor,
    output logic       dir
);

    logic [7:0]           mem [FIFOSZ];
    logic [FIFOSZ-1:0]    valid;
    logic [FIFOPTRSZ-1:0] wptr;
    logic [FIFOPTRSZ-1:0] rptr;
    logic                 wr;

    // Entries fill and drain in ring order, so an invalid head means empty.
    assign wr   = we & ~valid[wptr];
    assign dir  = ~(&valid);
    assign dor  = valid[rptr];
    assign dout = mem[rptr];

    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            valid <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (wr) begin
                valid[wptr] <= 1'b1;
                wptr        <= FIFOPTRSZ'(ptr_next(32'(wptr), FIFOSZ));
            end
            if (pop) begin
                valid[rptr] <= 1'b0;
                rptr        <= FIFOPTRSZ'(ptr_next(32'(rptr), FIFOSZ));
            end
        end
    end

    always_ff @(negedge clk) begin
        if (wr) mem[wptr] <= din;
    end

endmodule

// File: rtl/txfifo_ser.sv
// Transmit FIFO plus UART-style serializer (start, 8 data LSB-first, stop).
// Define TXFIFO_PARITY_EN to insert an even-parity bit before the stop bit.
module txfifo_ser
    import txfifo_pkg::*;
#(
    parameter int FIFOSZ    = FIFOSZ_DEF,
    parameter int FIFOPTRSZ = FIFOPTRSZ_DEF,
    parameter int CLKDIV    = 16,
    parameter int CNTSZ     = 4
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic [7:0] host_din,
    input  logic       host_we,
    output logic       host_dir,
    output logic       empty,
    input  logic       cts_b,
    output logic       tx_busy,
    output logic       txd
);

    logic [7:0]       dout;
    logic             dor;
    logic             pop;
    tx_state_t        state;
    logic [CNTSZ-1:0] timer;
    logic [2:0]       bidx;
    logic [7:0]       shreg;
    logic             bit_end;
`ifdef TXFIFO_PARITY_EN
    logic             par;
`endif

    txfifo_buf #(
        .FIFOSZ   (FIFOSZ),
        .FIFOPTRSZ(FIFOPTRSZ)
    ) u_buf (
        .clk    (clk),
        .reset_b(reset_b),
        .din    (host_din),
        .we     (host_we),
        .pop    (pop),
        .dout   (dout),
        .dor    (dor),
        .dir    (host_dir)
    );

    assign bit_end = (timer == CNTSZ'(CLKDIV - 1));
    assign pop     = (state == IDLE) & dor & ~cts_b;
    assign tx_busy = (state != IDLE);
    assign empty   = ~dor & ~tx_busy;

    // STOP always returns to IDLE first, giving the one-clk inter-frame gap.
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
            timer <= '0;
            bidx  <= '0;
            shreg <= '0;
            txd   <= 1'b1;
`ifdef TXFIFO_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            timer <= bit_end ? '0 : timer + 1'b1;
            unique case (state)
                IDLE: begin
                    timer <= '0;
                    if (pop) begin
                        state <= START;
                        shreg <= dout;
                        txd   <= 1'b0;
`ifdef TXFIFO_PARITY_EN
                        par   <= ^dout;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        txd   <= shreg[0];
                        bidx  <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bidx == 3'd7) begin
`ifdef TXFIFO_PARITY_EN
                            state <= PARITY;
                            txd   <= par;
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            shreg <= shreg >> 1;
                            txd   <= shreg[1];
                            bidx  <= bidx + 1'b1;
                        end
                    end
                end
`ifdef TXFIFO_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_txfifo_ser.sv
// Directed bench for txfifo_ser at CLKDIV=4, FIFOSZ=3.
// Expected frames come from a bit-position model of the serial format.
module tb_txfifo_ser;

    localparam int CLKDIV = 4;
`ifdef TXFIFO_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CLKDIV;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic [7:0] host_din = '0;
    logic       host_we = 1'b0;
    logic       host_dir;
    logic       empty;
    logic       cts_b = 1'b0;
    logic       tx_busy;
    logic       txd;

    int checks = 0;
    int errors = 0;

    txfifo_ser #(
        .FIFOSZ   (3),
        .FIFOPTRSZ(2),
        .CLKDIV   (CLKDIV),
        .CNTSZ    (4)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .host_din(host_din),
        .host_we (host_we),
        .host_dir(host_dir),
        .empty   (empty),
        .cts_b   (cts_b),
        .tx_busy (tx_busy),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int i);
        int k;
        k = i / CLKDIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef TXFIFO_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Called #1 after the edge where txd fell, with `first` cycles already
    // consumed; returns #1 after the edge that ends the stop bit.
    task automatic check_frame(input logic [7:0] b, input int first);
        for (int i = first; i < FL; i++) begin
            chk($sformatf("txd_%02h_c%0d", b, i), 32'(txd), 32'(exp_bit(b, i)));
            chk($sformatf("busy_%02h_c%0d", b, i), 32'(tx_busy), 32'd1);
            step();
        end
        chk($sformatf("end_busy_%02h", b), 32'(tx_busy), 32'd0);
        chk($sformatf("end_txd_%02h", b), 32'(txd), 32'd1);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_dir", 32'(host_dir), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        reset_b = 1'b1;
        step();

        // Single frame 0x55
        host_din = 8'h55;
        host_we  = 1'b1;
        step();
        host_we = 1'b0;
        chk("w55_empty", 32'(empty), 32'd0);
        chk("w55_txd_pre", 32'(txd), 32'd1);
        step();
        check_frame(8'h55, 0);
        chk("f55_empty", 32'(empty), 32'd1);
        step();

        // Fill with cts_b high; fourth write dropped
        cts_b = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            host_din = 8'(i);
            host_we  = 1'b1;
            step();
            chk($sformatf("fill_dir_%0d", i), 32'(host_dir), (i >= 3) ? 32'd0 : 32'd1);
        end
        host_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("hold_txd_%0d", i), 32'(txd), 32'd1);
            step();
        end
        chk("hold_empty", 32'(empty), 32'd0);
        chk("hold_busy", 32'(tx_busy), 32'd0);

        // Release cts_b with a write on the pop edge (dropped)
        cts_b    = 1'b0;
        host_din = 8'hAA;
        host_we  = 1'b1;
        step();
        chk("pop_txd", 32'(txd), 32'd0);
        chk("pop_busy", 32'(tx_busy), 32'd1);
        chk("pop_dir", 32'(host_dir), 32'd1);
        host_din = 8'hBB;
        step();
        host_we = 1'b0;
        chk("refill_dir", 32'(host_dir), 32'd0);
        check_frame(8'h01, 1);
        step();
        check_frame(8'h02, 0);
        step();
        check_frame(8'h03, 0);
        step();
        check_frame(8'hBB, 0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_dir", 32'(host_dir), 32'd1);
        step();
        chk("gap_txd", 32'(txd), 32'd1);

        // Reset mid-DATA of 0xA5
        host_din = 8'hA5;
        host_we  = 1'b1;
        step();
        host_we = 1'b0;
        step();
        for (int i = 0; i < 10; i++) step();
        chk("mid_busy", 32'(tx_busy), 32'd1);
        chk("mid_txd", 32'(txd), 32'(exp_bit(8'hA5, 10)));
        #2;
        reset_b = 1'b0;
        #1;
        chk("arst_txd", 32'(txd), 32'd1);
        chk("arst_busy", 32'(tx_busy), 32'd0);
        step();
        reset_b = 1'b1;
        chk("arst_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("post_txd_%0d", i), 32'(txd), 32'd1);
            step();
        end
        chk("post_busy", 32'(tx_busy), 32'd0);

        // 0x07: parity bit of 1 when parity is built in
        host_din = 8'h07;
        host_we  = 1'b1;
        step();
        host_we = 1'b0;
        step();
        check_frame(8'h07, 0);
        chk("f07_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
